pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/sequence controller for the 12-bit program counter. It decides each instruction's next PC: sequential, absolute jump, relative branch, call or return. It owns a small return-address stack and a fetch/decode/halt state machine, and drives pc_value and fetch_en to instruction memory. It sits between decode and the instruction fetch path.

Parameters:
N, 11, MSB index of PC; PC width is N+1 bits
DEPTH, 4, return-stack entries (power of 2, ≥2)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
run  in  1  start execution from IDLE
stall  in  1  freeze sequencing this cycle
instr_valid  in  1  decode flags/target valid (sampled in DECODE only)
is_jump  in  1  absolute jump to target
is_branch  in  1  conditional relative branch
branch_cond  in  1  branch condition true
is_call  in  1  push pc+1, jump to target
is_ret  in  1  pop return address
is_halt  in  1  stop execution
target  in  N+1  absolute address, or two's-complement offset for branch
pc_value  out  N+1  current instruction address
fetch_en  out  1  instruction-memory read strobe
state  out  2  FSM state
halted  out  1  high in HALT
stack_err  out  1  sticky; overflow/underflow occurred

Behaviour:
- Reset (sync, rst=1 at posedge): pc_value=0, state=IDLE, fetch_en=0, halted=0, stack_err=0, stack pointer=0 (empty). rst overrides every other input, in every state, including mid-operation.
- States: IDLE=2'b00, FETCH=2'b01, DECODE=2'b10, HALT=2'b11.
- IDLE: outputs hold. run=1 -> FETCH next cycle. pc stays at 0 or its last value.
- FETCH: fetch_en=1, registered, high for exactly the cycles state==FETCH.
  - stall=0 -> DECODE.
  - stall=1 -> stay in FETCH with fetch_en held high.
- DECODE: fetch_en=0. Wait until instr_valid=1 and stall=0. Flags are ignored otherwise.
- DECODE resolution, highest priority first:
  1. is_halt -> HALT, pc unchanged.
  2. is_ret: stack empty -> stack_err=1, HALT, pc unchanged. Else pc <= top, pop.
  3. is_call: stack full -> stack_err=1, HALT, pc unchanged. Else push pc+1, pc <= target.
  4. is_jump -> pc <= target.
  5. is_branch & branch_cond -> pc <= pc + target (signed, modulo 2^(N+1)).
  6. Otherwise (including branch not taken) -> pc <= pc + 1.
  - Every case except HALT -> FETCH next cycle.
- Arithmetic: all PC math is N+1 bits, carry discarded.
  - 0xFFF+1 = 0x000.
  - Branch 0x005 + 0xFFE = 0x003.
  - Pushed pc+1 wraps the same way.
- Latency:
  - New pc visible on the posedge that leaves DECODE.
  - fetch_en for that pc is asserted the following cycle (FETCH).
  - Each non-stalled instruction takes 2 cycles.
- HALT: halted=1, fetch_en=0, pc frozen. Exit only via rst; run is ignored.
- Stack: LIFO, DEPTH entries.
  - Push and pop never occur in the same cycle (priority rule guarantees this).
  - Contents are not cleared on reset; only the pointer is.
- stack_err: set together with the HALT transition, cleared only by rst.

Decomposition:
- Package pc_seq_pkg: state encodings (IDLE/FETCH/DECODE/HALT), PC_W = N+1 default 12, PC_RESET = 0.
- One sub-module, ret_stack (params N, DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout (top), full, empty.
  - Synchronous reset of the pointer only.

Test Plan:
1. Reset, run=1, instr_valid=1, no flags, for 8 cycles -> pc sequence 0,1,2,3. fetch_en high every other cycle, first in the cycle after run.
2. pc=0x004, is_call target=0x100 -> pc=0x100, stack top=0x005. Then is_ret -> pc=0x005, stack empty.
3. pc=0x005, is_branch, branch_cond=1, target=0xFFE -> pc=0x003. Same with branch_cond=0 -> pc=0x006. pc=0xFFF sequential -> pc=0x000.
4. Five nested calls with DEPTH=4 -> first four push. Fifth: stack_err=1, state=HALT, pc unchanged. run ignored. rst -> all reset values.
5. is_ret on empty stack -> stack_err=1, HALT. Simultaneous is_jump and is_call -> call wins (push occurs).
6. stall=1 for 3 cycles in FETCH and DECODE -> state/pc frozen, fetch_en held in FETCH. rst asserted in DECODE -> next cycle IDLE, pc=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: PC width, reset address
// and the fetch/decode/halt state encoding.
package pc_seq_pkg;

    localparam int unsigned PC_W     = 12;
    localparam int unsigned PC_RESET = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_DECODE = 2'b10,
        ST_HALT   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack. Only the pointer is reset; entry contents persist.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned N     = PC_W - 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [N:0] din,
    output logic [N:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] sp;
    logic [N:0]       mem [DEPTH];

    assign full  = (sp == PTR_W'(DEPTH));
    assign empty = (sp == '0);
    // sp points one past the top; an empty stack reads a don't-care entry
    assign dout  = mem[IDX_W'(sp - PTR_W'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[sp[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/decode/halt FSM choosing sequential, jump,
// branch, call or return as each instruction's next PC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned N     = PC_W - 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       stall,
    input  logic       instr_valid,
    input  logic       is_jump,
    input  logic       is_branch,
    input  logic       branch_cond,
    input  logic       is_call,
    input  logic       is_ret,
    input  logic       is_halt,
    input  logic [N:0] target,
    output logic [N:0] pc_value,
    output logic       fetch_en,
    output logic [1:0] state,
    output logic       halted,
    output logic       stack_err
);

    localparam int unsigned W = N + 1;

    seq_state_t state_q, state_d;
    logic [N:0] pc_q, pc_d;
    logic       err_q, err_d;
    logic       fetch_en_q, halted_q;
    logic       push, pop;
    logic [N:0] stk_top;
    logic       stk_full, stk_empty;

    ret_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_q + W'(1)),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc_value  = pc_q;
    assign fetch_en  = fetch_en_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign stack_err = err_q;

    // Next-state and next-PC resolution
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!stall) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (instr_valid && !stall) begin
                    state_d = ST_FETCH;
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else if (is_ret) begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_d = stk_top;
                            pop  = 1'b1;
                        end
                    end else if (is_call) begin
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_d = target;
                            push = 1'b1;
                        end
                    end else if (is_jump) begin
                        pc_d = target;
                    end else if (is_branch && branch_cond) begin
                        // two's-complement offset: unsigned add modulo 2^W is the same
                        pc_d = pc_q + target;
                    end else begin
                        pc_d = pc_q + W'(1);
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= W'(PC_RESET);
            err_q      <= 1'b0;
            fetch_en_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            fetch_en_q <= (state_d == ST_FETCH);
            halted_q   <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus random instruction mix
// against an instruction-level reference model.
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_FETCH  = 2'b01;
    localparam logic [1:0] S_DECODE = 2'b10;
    localparam logic [1:0] S_HALT   = 2'b11;

    logic        clk = 1'b0;
    logic        rst, run, stall, instr_valid;
    logic        is_jump, is_branch, branch_cond, is_call, is_ret, is_halt;
    logic [11:0] target;
    logic [11:0] pc_value;
    logic        fetch_en, halted, stack_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [11:0] m_pc;
    logic [11:0] m_stack [$];
    logic        m_err, m_halted;

    pc_sequencer #(.N(11), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .stall       (stall),
        .instr_valid (instr_valid),
        .is_jump     (is_jump),
        .is_branch   (is_branch),
        .branch_cond (branch_cond),
        .is_call     (is_call),
        .is_ret      (is_ret),
        .is_halt     (is_halt),
        .target      (target),
        .pc_value    (pc_value),
        .fetch_en    (fetch_en),
        .state       (state),
        .halted      (halted),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_flags();
        instr_valid = 1'b0; is_jump = 1'b0; is_branch = 1'b0; branch_cond = 1'b0;
        is_call = 1'b0; is_ret = 1'b0; is_halt = 1'b0; target = 12'h000;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},     32'(pc_value),  32'(m_pc));
        check({tag, ".state"},  32'(state),     m_halted ? 32'(S_HALT) : 32'(S_FETCH));
        check({tag, ".fetch"},  32'(fetch_en),  32'(!m_halted));
        check({tag, ".halted"}, 32'(halted),    32'(m_halted));
        check({tag, ".err"},    32'(stack_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; stall = 1'b0;
        clear_flags();
        tick();
        rst = 1'b0;
        m_pc = 12'h000; m_stack.delete(); m_err = 1'b0; m_halted = 1'b0;
        check("rst.pc",     32'(pc_value),  32'h0);
        check("rst.state",  32'(state),     32'(S_IDLE));
        check("rst.fetch",  32'(fetch_en),  32'h0);
        check("rst.halted", 32'(halted),    32'h0);
        check("rst.err",    32'(stack_err), 32'h0);
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
        check("start.state", 32'(state),    32'(S_FETCH));
        check("start.fetch", 32'(fetch_en), 32'h1);
    endtask

    // Instruction-level model: what the next PC, stack and status become.
    task automatic model_exec(input logic j, b, c, ca, r, h, input logic [11:0] t);
        if (h) begin
            m_halted = 1'b1;
        end else if (r) begin
            if (m_stack.size() == 0) begin m_err = 1'b1; m_halted = 1'b1; end
            else m_pc = m_stack.pop_back();
        end else if (ca) begin
            if (m_stack.size() == DEPTH) begin m_err = 1'b1; m_halted = 1'b1; end
            else begin m_stack.push_back(m_pc + 12'd1); m_pc = t; end
        end else if (j) begin
            m_pc = t;
        end else if (b && c) begin
            m_pc = m_pc + t;
        end else begin
            m_pc = m_pc + 12'd1;
        end
    endtask

    // Starts in FETCH; optional stall cycles, then DECODE, then resolution.
    task automatic do_instr(input string tag, input logic j, b, c, ca, r, h,
                            input logic [11:0] t, input int stalls);
        instr_valid = 1'b1; is_jump = j; is_branch = b; branch_cond = c;
        is_call = ca; is_ret = r; is_halt = h; target = t;
        for (int k = 0; k < stalls; k++) begin
            stall = 1'b1;
            tick();
            check({tag, ".fstall_state"}, 32'(state),    32'(S_FETCH));
            check({tag, ".fstall_fetch"}, 32'(fetch_en), 32'h1);
            check({tag, ".fstall_pc"},    32'(pc_value), 32'(m_pc));
        end
        stall = 1'b0;
        tick();
        check({tag, ".dec_state"}, 32'(state),    32'(S_DECODE));
        check({tag, ".dec_fetch"}, 32'(fetch_en), 32'h0);
        tick();
        model_exec(j, b, c, ca, r, h, t);
        check_all(tag);
        clear_flags();
    endtask

    initial begin
        logic [11:0] pc_before;
        rst = 1'b1; run = 1'b0; stall = 1'b0;
        clear_flags();

        // 1: reset, IDLE holds without run, sequential fetch 0..3
        do_reset();
        tick();
        check("idle.state", 32'(state), 32'(S_IDLE));
        start();
        check("seq.pc0", 32'(pc_value), 32'h0);
        for (int i = 0; i < 4; i++) do_instr("seq", 0, 0, 0, 0, 0, 0, 12'h000, 0);
        check("seq.pc4", 32'(pc_value), 32'h4);

        // 2: call / return
        do_instr("call", 0, 0, 0, 1, 0, 0, 12'h100, 0);
        check("call.pc", 32'(pc_value), 32'h100);
        check("call.top", 32'(u_dut.u_stack.dout), 32'h005);
        do_instr("ret", 0, 0, 0, 0, 1, 0, 12'h000, 0);
        check("ret.pc", 32'(pc_value), 32'h005);
        check("ret.empty", 32'(u_dut.u_stack.empty), 32'h1);

        // 3: branch taken / not taken, wrap
        do_instr("br_t", 0, 1, 1, 0, 0, 0, 12'hFFE, 0);
        check("br_t.pc", 32'(pc_value), 32'h003);
        do_instr("jmp5", 1, 0, 0, 0, 0, 0, 12'h005, 0);
        do_instr("br_nt", 0, 1, 0, 0, 0, 0, 12'hFFE, 0);
        check("br_nt.pc", 32'(pc_value), 32'h006);
        do_instr("jmpfff", 1, 0, 0, 0, 0, 0, 12'hFFF, 0);
        do_instr("wrap", 0, 0, 0, 0, 0, 0, 12'h000, 0);
        check("wrap.pc", 32'(pc_value), 32'h000);

        // 4: nested calls overflow, run ignored in HALT, reset recovers
        for (int i = 1; i <= 5; i++) do_instr("ncall", 0, 0, 0, 1, 0, 0, 12'(i * 16), 0);
        check("ovf.pc",    32'(pc_value),  32'h040);
        check("ovf.err",   32'(stack_err), 32'h1);
        check("ovf.state", 32'(state),     32'(S_HALT));
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt.run_state", 32'(state),    32'(S_HALT));
            check("halt.run_pc",    32'(pc_value), 32'h040);
            check("halt.run_fetch", 32'(fetch_en), 32'h0);
        end
        do_reset();

        // 5: return on empty stack; jump+call together
        start();
        do_instr("ret_empty", 0, 0, 0, 0, 1, 0, 12'h000, 0);
        check("ret_empty.err", 32'(stack_err), 32'h1);
        do_reset();
        start();
        do_instr("jmpcall", 1, 0, 0, 1, 0, 0, 12'h200, 0);
        check("jmpcall.top", 32'(u_dut.u_stack.dout), 32'h001);
        do_instr("jmpcall_ret", 0, 0, 0, 0, 1, 0, 12'h000, 0);
        check("jmpcall_ret.pc", 32'(pc_value), 32'h001);

        // 6: stalls in FETCH and DECODE, invalid DECODE, reset in DECODE
        do_instr("fstall", 1, 0, 0, 0, 0, 0, 12'h0AB, 3);
        stall = 1'b0;
        tick();
        pc_before = m_pc;
        instr_valid = 1'b1; is_jump = 1'b1; target = 12'h321; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dstall.state", 32'(state),    32'(S_DECODE));
            check("dstall.pc",    32'(pc_value), 32'(pc_before));
            check("dstall.fetch", 32'(fetch_en), 32'h0);
        end
        stall = 1'b0; instr_valid = 1'b0;
        tick();
        check("dinval.state", 32'(state), 32'(S_DECODE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_dec.state", 32'(state),    32'(S_IDLE));
        check("rst_dec.pc",    32'(pc_value), 32'h0);
        clear_flags();

        // random instruction mix
        do_reset();
        start();
        for (int i = 0; i < 300; i++) begin
            logic h, r, ca, j, b, c;
            logic [11:0] t;
            int st;
            if (m_halted) begin
                do_reset();
                start();
            end
            h  = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 9) < 2);
            ca = ($urandom_range(0, 9) < 2);
            j  = ($urandom_range(0, 9) < 2);
            b  = ($urandom_range(0, 9) < 3);
            c  = 1'($urandom);
            t  = 12'($urandom);
            st = ($urandom_range(0, 7) == 0) ? 1 : 0;
            do_instr("rnd", j, b, c, ca, r, h, t, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
